wb_queue: RTL and testbench

Write-back queue sitting directly upstream of the 8x16 register file. It buffers register writes produced by the execute/memory side and drains them, one per cycle, onto the file's single write port: write select, write data and write enable. It also gives the decode stage per-port hazard flags for its two read selects. With forwarding compiled in, it also supplies the youngest in-flight data, so decode does not read stale register values.

---
 rtl/wb_queue_if.sv | 35 +++
 rtl/wb_queue.sv | 121 ++++++++++++
 tb/tb_wb_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Handshake and lookup bundle between the write-back queue,
// its producer, the register-file write port and decode.
interface wb_queue_if #(
    parameter int CW = 3
);
    logic          inValid;
    logic          inReady;
    logic [2:0]    inReg;
    logic [15:0]   inData;
    logic          wbStall;
    logic          writeEn;
    logic [2:0]    writeRegSel;
    logic [15:0]   writeData;
    logic [2:0]    readReg1Sel;
    logic [2:0]    readReg2Sel;
    logic          hit1;
    logic          hit2;
    logic [15:0]   fwdData1;
    logic [15:0]   fwdData2;
    logic [CW-1:0] count;

    modport master (
        output inValid, inReg, inData, wbStall,
        output readReg1Sel, readReg2Sel,
        input  inReady, writeEn, writeRegSel, writeData,
        input  hit1, hit2, fwdData1, fwdData2, count
    );

    modport slave (
        input  inValid, inReg, inData, wbStall,
        input  readReg1Sel, readReg2Sel,
        output inReady, writeEn, writeRegSel, writeData,
        output hit1, hit2, fwdData1, fwdData2, count
    );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue in front of the 8x16 register file with decode hazard lookup.
// Define WBQ_FORWARD_EN to drive fwdData1/fwdData2 with the youngest match.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    wb_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]  rg;
        logic [15:0] data;
        logic        valid;
    } entry_t;

    entry_t        q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    // inReady depends only on registered occupancy, never on wbStall
    assign bus.inReady = !full && rst;
    assign bus.writeEn = !empty && !bus.wbStall && rst;
    assign push        = bus.inValid && bus.inReady;
    assign pop         = bus.writeEn;

    assign bus.writeRegSel = empty ? 3'd0  : q[head].rg;
    assign bus.writeData   = empty ? 16'd0 : q[head].data;
    assign bus.count       = cnt;

    // push and pop never hit the same slot: that needs empty or full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail == AW'(i)) begin
                    q[i] <= '{rg: bus.inReg, data: bus.inData, valid: 1'b1};
                end else if (pop && head == AW'(i)) begin
                    q[i].valid <= 1'b0;
                end
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    logic [AW-1:0] idx;
    logic          hit1;
    logic          hit2;

    // scan oldest to youngest so the last match left standing is youngest
    always_comb begin
        idx  = head;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (q[idx].valid && q[idx].rg == bus.readReg1Sel) begin
                hit1 = 1'b1;
            end
            if (q[idx].valid && q[idx].rg == bus.readReg2Sel) begin
                hit2 = 1'b1;
            end
        end
    end

    assign bus.hit1 = hit1;
    assign bus.hit2 = hit2;

`ifdef WBQ_FORWARD_EN
    logic [AW-1:0] fidx;
    logic [15:0]   fwd1;
    logic [15:0]   fwd2;

    always_comb begin
        fidx = head;
        fwd1 = 16'd0;
        fwd2 = 16'd0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = head + AW'(k);
            if (q[fidx].valid && q[fidx].rg == bus.readReg1Sel) begin
                fwd1 = q[fidx].data;
            end
            if (q[fidx].valid && q[fidx].rg == bus.readReg2Sel) begin
                fwd2 = q[fidx].data;
            end
        end
    end

    assign bus.fwdData1 = fwd1;
    assign bus.fwdData2 = fwd2;
`else
    assign bus.fwdData1 = 16'd0;
    assign bus.fwdData2 = 16'd0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst;

    wb_queue_if #(.CW(CW)) bus ();

    wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rg;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] rf_ref [8];
    logic [15:0] rf_dut [8];

    int errors = 0;
    int checks = 0;

    logic        e_rdy, e_we, e_h1, e_h2;
    logic [2:0]  e_sel;
    logic [15:0] e_data, e_f1, e_f2;
    int          e_cnt;

    always @(posedge clk)
        if (bus.writeEn) rf_dut[bus.writeRegSel] <= bus.writeData;

    task automatic drive(input logic v, input logic [2:0] r,
                         input logic [15:0] d, input logic s);
        bus.inValid = v;
        bus.inReg   = r;
        bus.inData  = d;
        bus.wbStall = s;
    endtask

    // expected combinational outputs from the model's current contents
    task automatic eval();
        #1;
        e_cnt  = mq.size();
        e_rdy  = rst && (mq.size() != DEPTH);
        e_we   = rst && (mq.size() != 0) && !bus.wbStall;
        e_sel  = (mq.size() != 0) ? mq[0].rg : 3'd0;
        e_data = (mq.size() != 0) ? mq[0].data : 16'd0;
        e_h1 = 1'b0; e_h2 = 1'b0; e_f1 = 16'd0; e_f2 = 16'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!e_h1 && mq[i].rg == bus.readReg1Sel) begin
                e_h1 = 1'b1; e_f1 = mq[i].data;
            end
            if (!e_h2 && mq[i].rg == bus.readReg2Sel) begin
                e_h2 = 1'b1; e_f2 = mq[i].data;
            end
        end
`ifndef WBQ_FORWARD_EN
        e_f1 = 16'd0;
        e_f2 = 16'd0;
`endif
    endtask

    task automatic tick();
        bit push, pop;
        ent_t e;
        push = bus.inValid && rst && (mq.size() != DEPTH);
        pop  = rst && (mq.size() != 0) && !bus.wbStall;
        e.rg = bus.inReg;
        e.data = bus.inData;
        @(posedge clk);
        if (pop) begin
            rf_ref[mq[0].rg] = mq[0].data;
            void'(mq.pop_front());
        end
        if (push) mq.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 3'd1, 16'h1111, 1'b0);
        bus.readReg1Sel = 3'd1;
        bus.readReg2Sel = 3'd1;
        repeat (2) @(negedge clk);
        eval();
        checks++;
        if (bus.writeEn !== 1'b0 || bus.inReady !== 1'b0 || bus.count !== '0) begin
            errors++;
            $display("FAIL reset_hold: we=%b rdy=%b cnt=%0d want 0 0 0",
                     bus.writeEn, bus.inReady, bus.count);
        end
        checks++;
        if (bus.hit1 !== 1'b0 || bus.writeData !== 16'd0 || bus.fwdData1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_outs: hit1=%b wd=%h f1=%h want 0", bus.hit1,
                     bus.writeData, bus.fwdData1);
        end
        tick();
        bus.inValid = 1'b0;
        rst = 1'b1;
        eval();
        checks++;
        if (bus.inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b want 1", bus.inReady);
        end
        tick();
        eval();
        checks++;
        if (bus.writeEn !== 1'b0 || bus.count !== CW'(e_cnt)) begin
            errors++;
            $display("FAIL reset_nodrain: we=%b cnt=%0d want 0 %0d",
                     bus.writeEn, bus.count, e_cnt);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 3'd3, 16'hBEEF, 1'b0);
        bus.readReg1Sel = 3'd3;
        eval();
        checks++;
        if (bus.writeEn !== 1'b0 || bus.hit1 !== 1'b0) begin
            errors++;
            $display("FAIL single_nofall: we=%b hit1=%b want 0 0", bus.writeEn, bus.hit1);
        end
        tick();
        bus.inValid = 1'b0;
        eval();
        checks++;
        if (bus.writeEn !== 1'b1 || bus.writeRegSel !== 3'd3 || bus.writeData !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_wr: we=%b sel=%0d d=%h want 1 3 beef",
                     bus.writeEn, bus.writeRegSel, bus.writeData);
        end
        checks++;
        if (bus.hit1 !== 1'b1 || bus.fwdData1 !== e_f1) begin
            errors++;
            $display("FAIL single_hit: hit1=%b f1=%h want 1 %h", bus.hit1, bus.fwdData1, e_f1);
        end
        tick();
        eval();
        checks++;
        if (bus.count !== '0 || bus.hit1 !== 1'b0 || rf_dut[3] !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_after: cnt=%0d hit1=%b rf3=%h want 0 0 beef",
                     bus.count, bus.hit1, rf_dut[3]);
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b1);
            tick();
        end
        bus.inValid = 1'b0;
        eval();
        checks++;
        if (bus.count !== CW'(DEPTH) || bus.inReady !== 1'b0 || bus.writeEn !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d rdy=%b we=%b want %0d 0 0",
                     bus.count, bus.inReady, bus.writeEn, DEPTH);
        end
        bus.wbStall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            eval();
            checks++;
            if (bus.writeEn !== 1'b1 || bus.writeRegSel !== 3'(i) ||
                bus.writeData !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL fill_drain%0d: we=%b sel=%0d d=%h want 1 %0d %h", i,
                         bus.writeEn, bus.writeRegSel, bus.writeData, i, 16'h1000 + 16'(i));
            end
            tick();
        end
        eval();
        checks++;
        if (bus.count !== '0 || bus.writeEn !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: cnt=%0d we=%b want 0 0", bus.count, bus.writeEn);
        end
    endtask

    task automatic test_youngest();
        bus.readReg2Sel = 3'd5;
        drive(1'b1, 3'd5, 16'h0001, 1'b1);
        tick();
        drive(1'b1, 3'd5, 16'h0002, 1'b1);
        tick();
        bus.inValid = 1'b0;
        eval();
        checks++;
        if (bus.hit2 !== 1'b1 || bus.fwdData2 !== e_f2) begin
            errors++;
            $display("FAIL youngest: hit2=%b f2=%h want 1 %h", bus.hit2, bus.fwdData2, e_f2);
        end
        bus.wbStall = 1'b0;
        tick();
        eval();
        checks++;
        if (bus.hit2 !== 1'b1 || bus.fwdData2 !== e_f2 || rf_dut[5] !== 16'h0001) begin
            errors++;
            $display("FAIL youngest_mid: hit2=%b f2=%h rf5=%h want 1 %h 0001",
                     bus.hit2, bus.fwdData2, rf_dut[5], e_f2);
        end
        tick();
        eval();
        checks++;
        if (bus.hit2 !== 1'b0 || rf_dut[5] !== 16'h0002) begin
            errors++;
            $display("FAIL youngest_final: hit2=%b rf5=%h want 0 0002", bus.hit2, rf_dut[5]);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 3'(i + 2), 16'h2000 + 16'(i), 1'b1);
            tick();
        end
        drive(1'b1, 3'd7, 16'hDEAD, 1'b0);
        eval();
        checks++;
        if (bus.inReady !== 1'b0 || bus.writeEn !== 1'b1) begin
            errors++;
            $display("FAIL full_simul: rdy=%b we=%b want 0 1", bus.inReady, bus.writeEn);
        end
        tick();
        bus.inValid = 1'b0;
        bus.wbStall = 1'b1;
        eval();
        checks++;
        if (bus.count !== CW'(DEPTH - 1) || bus.writeRegSel !== 3'd3) begin
            errors++;
            $display("FAIL full_after: cnt=%0d sel=%0d want %0d 3",
                     bus.count, bus.writeRegSel, DEPTH - 1);
        end
        bus.wbStall = 1'b0;
        repeat (DEPTH) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        for (int i = 0; i < 10; i++) begin
            d = 16'($urandom);
            drive(1'b1, 3'($urandom_range(0, 7)), d, 1'b0);
            bus.readReg1Sel = 3'($urandom_range(0, 7));
            eval();
            checks++;
            if (bus.writeEn !== e_we || bus.writeRegSel !== e_sel ||
                bus.writeData !== e_data || bus.count !== CW'(e_cnt)) begin
                errors++;
                $display("FAIL b2b%0d: we=%b sel=%0d d=%h cnt=%0d want %b %0d %h %0d", i,
                         bus.writeEn, bus.writeRegSel, bus.writeData, bus.count,
                         e_we, e_sel, e_data, e_cnt);
            end
            tick();
        end
        bus.inValid = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf_dut[r] !== rf_ref[r]) begin
                errors++;
                $display("FAIL b2b_rf%0d: got %h want %h", r, rf_dut[r], rf_ref[r]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                  16'($urandom), ($urandom_range(0, 3) == 0));
            bus.readReg1Sel = 3'($urandom_range(0, 3));
            bus.readReg2Sel = 3'($urandom_range(0, 3));
            eval();
            checks++;
            if (bus.inReady !== e_rdy || bus.writeEn !== e_we || bus.writeRegSel !== e_sel ||
                bus.writeData !== e_data || bus.count !== CW'(e_cnt) ||
                bus.hit1 !== e_h1 || bus.hit2 !== e_h2 ||
                bus.fwdData1 !== e_f1 || bus.fwdData2 !== e_f2) begin
                errors++;
                $display("FAIL rand%0d: rdy=%b we=%b sel=%0d d=%h cnt=%0d h=%b%b f=%h/%h want %b %b %0d %h %0d %b%b %h/%h",
                         i, bus.inReady, bus.writeEn, bus.writeRegSel, bus.writeData,
                         bus.count, bus.hit1, bus.hit2, bus.fwdData1, bus.fwdData2,
                         e_rdy, e_we, e_sel, e_data, e_cnt, e_h1, e_h2, e_f1, e_f2);
            end
            tick();
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] snap [8];
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(i + 4), 16'hC000 + 16'(i), 1'b1);
            tick();
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0);
        snap = rf_dut;
        rst = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (bus.writeEn !== 1'b0 || bus.count !== '0) begin
            errors++;
            $display("FAIL midrst: we=%b cnt=%0d want 0 0", bus.writeEn, bus.count);
        end
        #3;
        rst = 1'b1;
        #0.5;
        checks++;
        if (bus.inReady !== 1'b1 || bus.writeEn !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: rdy=%b we=%b want 1 0", bus.inReady, bus.writeEn);
        end
        @(negedge clk);
        repeat (4) tick();
        for (int r = 4; r < 7; r++) begin
            checks++;
            if (rf_dut[r] !== snap[r]) begin
                errors++;
                $display("FAIL midrst_rf%0d: got %h want %h", r, rf_dut[r], snap[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            rf_ref[r] = 16'd0;
            rf_dut[r] = 16'd0;
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 1'b0);
        bus.readReg1Sel = 3'd0;
        bus.readReg2Sel = 3'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_stall();
        test_youngest();
        test_full_simul();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
